// File: rtl/rvh_ptw_miss_scheduler.sv
// rvh_ptw_miss_scheduler: shares one page-table walker between DTLB and ITLB misses with starvation-guarded fixed priority
module rvh_ptw_miss_scheduler #(
  parameter int DTLB_PRIOR   = 1,
  parameter int VPN_WIDTH    = 27,
  parameter int PTE_WIDTH    = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_WIDTH    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dtlb_miss_req_vld_i,
  input  logic [VPN_WIDTH-1:0] dtlb_miss_req_vpn_i,
  output logic                 dtlb_miss_req_rdy_o,
  input  logic                 itlb_miss_req_vld_i,
  input  logic [VPN_WIDTH-1:0] itlb_miss_req_vpn_i,
  output logic                 itlb_miss_req_rdy_o,
  output logic                 ptw_req_vld_o,
  output logic [VPN_WIDTH-1:0] ptw_req_vpn_o,
  input  logic                 ptw_req_rdy_i,
  input  logic                 ptw_resp_vld_i,
  input  logic [PTE_WIDTH-1:0] ptw_resp_pte_i,
  input  logic                 ptw_resp_fault_i,
  output logic                 dtlb_miss_resp_vld_o,
  output logic [PTE_WIDTH-1:0] dtlb_miss_resp_pte_o,
  output logic                 dtlb_miss_resp_fault_o,
  output logic                 itlb_miss_resp_vld_o,
  output logic [PTE_WIDTH-1:0] itlb_miss_resp_pte_o,
  output logic                 itlb_miss_resp_fault_o,
  output logic                 busy_o
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2;
  localparam logic PRIO_I = (DTLB_PRIOR == 0);
  logic [1:0] state;
  logic owner;
  logic [VPN_WIDTH-1:0] vpn_q;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic idle, both, starved, grant_i, accept, resp;
  always_comb begin
    idle = !rst && state == IDLE;
    both = dtlb_miss_req_vld_i && itlb_miss_req_vld_i;
    starved = STARVE_LIMIT != 0 && starve_cnt == CNT_WIDTH'(STARVE_LIMIT);
    grant_i = both ? (PRIO_I ^ starved) : itlb_miss_req_vld_i;
    dtlb_miss_req_rdy_o = idle && dtlb_miss_req_vld_i && !grant_i;
    itlb_miss_req_rdy_o = idle && itlb_miss_req_vld_i && grant_i;
    accept = dtlb_miss_req_rdy_o || itlb_miss_req_rdy_o;
    resp = !rst && state == WAIT && ptw_resp_vld_i;
    ptw_req_vld_o = !rst && state == REQ;
    ptw_req_vpn_o = rst ? '0 : vpn_q;
    dtlb_miss_resp_vld_o = resp && !owner;
    itlb_miss_resp_vld_o = resp && owner;
    dtlb_miss_resp_pte_o = rst ? '0 : ptw_resp_pte_i;
    itlb_miss_resp_pte_o = rst ? '0 : ptw_resp_pte_i;
    dtlb_miss_resp_fault_o = !rst && ptw_resp_fault_i;
    itlb_miss_resp_fault_o = !rst && ptw_resp_fault_i;
    busy_o = !rst && state != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      vpn_q <= '0;
      starve_cnt <= '0;
    end else begin
      state <= accept ? REQ :
               (state == REQ && ptw_req_rdy_i) ? WAIT :
               (state == WAIT && ptw_resp_vld_i) ? IDLE : state;
      if (accept) begin
        owner <= grant_i;
        vpn_q <= grant_i ? itlb_miss_req_vpn_i : dtlb_miss_req_vpn_i;
        starve_cnt <= !(both && grant_i == PRIO_I) ? '0 :
                      starved ? starve_cnt : starve_cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: doc/rvh_ptw_miss_scheduler.md
# rvh_ptw_miss_scheduler

Sequential scheduler that shares the single page-table walker (PTW) between the DTLB and ITLB miss paths. It accepts one miss at a time from either TLB using a fixed-priority policy with a starvation guard. It issues the miss to the PTW with a valid/ready handshake, tracks the single outstanding walk, and routes the walk result back to the TLB that owns it. It sits between the two L1 TLBs and the PTW inside the MMU.

## Interface
- `DTLB_PRIOR`, 1 — 1: DTLB is the priority side; 0: ITLB is.
- `VPN_WIDTH`, 27 — virtual page number width.
- `PTE_WIDTH`, 64 — returned PTE width.
- `STARVE_LIMIT`, 4 — max consecutive priority grants while the other side waits; 0 disables the guard (pure fixed priority).
- `CNT_WIDTH`, 3 — starvation counter width; must hold `STARVE_LIMIT`.
- `clk` in 1 — clock; the single clock of the block.
- `rst` in 1 — reset, synchronous, active-high.
- `dtlb_miss_req_vld_i` in 1 — DTLB miss request.
- `dtlb_miss_req_vpn_i` in VPN_WIDTH — DTLB miss VPN.
- `dtlb_miss_req_rdy_o` out 1 — DTLB request accepted this cycle.
- `itlb_miss_req_vld_i` / `itlb_miss_req_vpn_i` / `itlb_miss_req_rdy_o` — same as the DTLB signals, for the ITLB.
- `ptw_req_vld_o` out 1 — walk request to PTW.
- `ptw_req_vpn_o` out VPN_WIDTH — walk VPN.
- `ptw_req_rdy_i` in 1 — PTW accepts the request.
- `ptw_resp_vld_i` in 1 — walk done.
- `ptw_resp_pte_i` in PTE_WIDTH — PTE from the walk.
- `ptw_resp_fault_i` in 1 — walk faulted.
- `dtlb_miss_resp_vld_o`, `dtlb_miss_resp_pte_o`, `dtlb_miss_resp_fault_o` out 1/PTE_WIDTH/1 — result to DTLB.
- `itlb_miss_resp_vld_o`, `itlb_miss_resp_pte_o`, `itlb_miss_resp_fault_o` out 1/PTE_WIDTH/1 — result to ITLB.
- `busy_o` out 1 — a walk is held or outstanding (state ≠ IDLE).

## Operation
- **State machine:** states are IDLE, REQ and WAIT. Registers are `state`, `owner` (0 = DTLB, 1 = ITLB), `vpn_q` and `starve_cnt`.
- **IDLE:** grant is computed combinationally from the two request valids.
  - Only one side valid: that side wins.
  - Both sides valid: the priority side wins, unless `STARVE_LIMIT != 0` and `starve_cnt == STARVE_LIMIT`; then the other side wins.
  - Only the winner's `*_rdy_o` is high, and it is high only while that side's vld is high.
  - On accept: latch the VPN into `vpn_q`, latch the winner into `owner`, then go to REQ.
- **Starvation counter:** updates on each accept.
  - Priority side granted while the other side's vld is high: `starve_cnt` +1, saturating at `STARVE_LIMIT`.
  - Any other grant: `starve_cnt` ← 0.
- **REQ:** `ptw_req_vld_o` = 1 and `ptw_req_vpn_o` = `vpn_q`. Both stay stable until `ptw_req_rdy_i`, then go to WAIT.
- **WAIT:** `ptw_req_vld_o` = 0.
  - When `ptw_resp_vld_i` is high: the owner's `*_resp_vld_o` = 1 in the same cycle, with pte/fault passed straight from the PTW inputs. The non-owner's resp_vld stays 0.
  - Next state is IDLE.
- **Ignored inputs:** `ptw_resp_vld_i` is ignored outside WAIT. `ptw_req_rdy_i` is ignored outside REQ.
- **Resp data outputs:** resp pte/fault outputs are driven from the PTW inputs at all times. Only the resp_vld outputs are qualified.
- **Single outstanding walk:** while in REQ or WAIT, both rdy outputs are 0.

## Timing
- **Reset values:** on the `clk` edge with `rst` = 1, state ← IDLE, `owner` ← 0, `vpn_q` ← 0, `starve_cnt` ← 0. While `rst` is high, all outputs are forced to 0, including the rdy outputs.
- **Reset mid-walk:** any walk in REQ or WAIT is abandoned with no response. A late `ptw_resp_vld_i` that arrives in IDLE is dropped.
- **Request latency:** accept in cycle T → `ptw_req_vld_o` high in T+1.
- **Response latency:** `ptw_resp_vld_i` in WAIT → TLB resp_vld in the same cycle (0 added latency). The next accept can happen no earlier than the following cycle.
- **Back-to-back throughput:** one accept every (PTW handshake cycles + PTW latency + 2) cycles at minimum.
- **Requester handshake:** a requester must hold vld and vpn stable until its rdy. A requester may drop vld before it is granted; nothing is latched in that case.

## Test plan
- **Single DTLB miss:** DTLB vld, vpn = 0x12345; `ptw_req_rdy_i` = 1; response 3 cycles later with pte = 0xDEAD, fault = 0.
  - `dtlb_rdy` high 1 cycle.
  - `ptw_req_vld_o` in the next cycle with vpn 0x12345.
  - `dtlb_resp_vld` for 1 cycle with pte 0xDEAD.
  - `itlb_resp_vld` stays 0.
- **Simultaneous requests, DTLB_PRIOR = 1:** DTLB is granted first and the ITLB is granted after the DTLB walk returns. Responses are routed to the correct owner; the ITLB response carries fault = 1 when the PTW faults.
- **Starvation, STARVE_LIMIT = 4:** DTLB and ITLB both requesting continuously.
  - Grant order: D, D, D, D, I, D, D, D, D, I…
  - `starve_cnt` returns to 0 after each ITLB grant.
- **PTW backpressure:** hold `ptw_req_rdy_i` = 0 for 5 cycles.
  - `ptw_req_vld_o` and vpn stay stable.
  - Both rdy outputs stay 0.
  - A spurious `ptw_resp_vld_i` during REQ is ignored.
- **Reset mid-WAIT:** assert `rst` for 1 cycle, then drive `ptw_resp_vld_i`.
  - No TLB resp_vld is produced.
  - The block returns to IDLE, `busy_o` = 0, and the next request is granted normally.
- **STARVE_LIMIT = 0, DTLB_PRIOR = 0:** both sides requesting continuously → ITLB always wins and DTLB is never granted.
